// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RV32M multiplier.
// Holds the operand width, the in_op encodings, the FSM state type,
// the step/latency constants and small helpers that decode the signedness
// of each operand from the operation code.
package mul_pkg;

  localparam int XLEN        = 32;
  localparam int MUL_STEPS   = 32;
  localparam int MUL_LATENCY = 36;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } mul_state_e;

  function automatic logic a_is_signed(input logic [1:0] op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic b_is_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Combinational 32-bit adder with carry in and carry out.
// Ports: a, b (32-bit operands), carry_in -> sum (32-bit), carry_out.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};

endmodule

// File: rtl/mul_seq_32.sv
// Sequential RV32M multiplier (MUL, MULH, MULHSU, MULHU) built around a
// single shared adder_32bit. Operands are made positive, multiplied by
// 32 shift-add steps, and the 64-bit product is negated when needed.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   synchronous kill, highest priority
//   in_valid/in_ready       operand handshake (in_ready only in IDLE)
//   in_op, in_a, in_b       operation code and rs1/rs2
//   out_valid/out_ready     result handshake, result held until accepted
//   out_result              low word for MUL, high word otherwise
//   busy                    any state other than IDLE
//
// state  | meaning
// IDLE   | waiting for operands
// ABS_A  | mcand = |a| (or a when a is unsigned / positive)
// ABS_B  | lo = |b| (or b), hi and step counter cleared
// MUL    | one shift-add step per cycle, 32 steps
// NEG_LO | two's-complement low word if result is negative, keep carry
// NEG_HI | two's-complement high word using carry from NEG_LO
// DONE   | result presented until out_ready
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  if (XLEN_P != 32) begin : g_xlen_check
    $error("mul_seq_32 only supports XLEN = 32");
  end

  mul_state_e  state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q, mcand_q, hi_q, lo_q;
  logic [4:0]  cnt_q;
  logic        neg_q, c_q;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        accept;

  assign accept = in_valid && (state_q == IDLE) && !flush;

  // Negation is done as ~x + 1 through the same adder; NEG_HI takes the
  // carry out of NEG_LO so the pair forms a 64-bit negate.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      ABS_A:  begin add_a = ~a_q; add_cin = 1'b1; end
      ABS_B:  begin add_a = ~b_q; add_cin = 1'b1; end
      MUL:    begin add_a = hi_q; add_b = lo_q[0] ? mcand_q : '0; end
      NEG_LO: begin add_a = ~lo_q; add_cin = 1'b1; end
      NEG_HI: begin add_a = ~hi_q; add_cin = c_q; end
      default: ;
    endcase
  end

  adder_32bit u_adder (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (add_cin),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ABS_A;
      ABS_A:   state_d = ABS_B;
      ABS_B:   state_d = MUL;
      MUL:     if (cnt_q == 5'(MUL_STEPS - 1)) state_d = NEG_LO;
      NEG_LO:  state_d = NEG_HI;
      NEG_HI:  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            neg_q <= (b_is_signed(in_op) && (in_a[31] ^ in_b[31])) ||
                     (in_op == MUL_OP_MULHSU && in_a[31]);
          end
        end
        ABS_A: mcand_q <= (a_is_signed(op_q) && a_q[31]) ? add_sum : a_q;
        ABS_B: begin
          lo_q  <= (b_is_signed(op_q) && b_q[31]) ? add_sum : b_q;
          hi_q  <= '0;
          cnt_q <= '0;
        end
        MUL: begin
          // Sum can reach 33 bits; its carry becomes the new top bit of hi.
          {hi_q, lo_q} <= {add_cout, add_sum, lo_q[31:1]};
          cnt_q        <= cnt_q + 5'd1;
        end
        NEG_LO: begin
          if (neg_q) begin
            lo_q <= add_sum;
            c_q  <= add_cout;
          end else begin
            c_q  <= 1'b0;
          end
        end
        NEG_HI: if (neg_q) hi_q <= add_sum;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = (state_q != DONE)    ? '0   :
                      (op_q == MUL_OP_MUL) ? lo_q : hi_q;

endmodule

// File: tb/tb_mul_seq_32.sv
module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam int LAT = 36;

  mul_seq_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: extend each operand to a wide signed integer according to
  // its RV32M signedness, multiply, then pick the requested word.
  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (op == 2'b11) ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
    sb = (op == 2'b00 || op == 2'b01) ? $signed({{34{b[31]}}, b})
                                      : $signed({34'd0, b});
    p = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issues one operation (caller is #1 after an edge with in_ready high),
  // scrambles the operand inputs after acceptance, and waits for out_valid.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        res = out_result;
        break;
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic recover();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_result=%h busy=%b, expected 1 0 0 0",
               in_ready, out_valid, out_result, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [10] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    logic [31:0] as  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'h80000000};
    logic [31:0] bs  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd5, 32'h80000000};
    logic [31:0] exp [10] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF,
                              32'hFFFFFFEB, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hC0000000};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat);
      n_cmp++;
      if (lat != LAT) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, expected %0d", i, lat, LAT);
      end
      n_cmp++;
      if (r !== exp[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: op=%0d a=%h b=%h got %h expected %h",
                 i, ops[i], as[i], bs[i], r, exp[i]);
      end
      if (lat < 0) recover(); else retire();
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, r, e;
    int lat;
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'h80000000;
        2: a = 32'($urandom_range(0, 3));
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      e = ref_mul(op, a, b);
      run_op(op, a, b, r, lat);
      n_cmp++;
      if (lat != LAT || r !== e) begin
        n_err++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h got %h after %0d cycles, expected %h after %0d",
                 i, op, a, b, r, lat, e, LAT);
      end
      if (lat < 0) recover(); else retire();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, e;
    int lat;
    e = ref_mul(2'b01, 32'h12345678, 32'h9ABCDEF0);
    run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, r, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== e || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: valid=%b result=%h in_ready=%b, expected 1 %h 0",
                 k, out_valid, out_result, in_ready, e);
      end
    end
    retire();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int lat;
    bit seen;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd1234; in_b = 32'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_no_valid: out_valid asserted=%b, expected 0", seen);
    end
    run_op(2'b11, 32'hDEADBEEF, 32'h0000FFFF, r, lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_done: valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    run_op(2'b10, 32'hFFFFFFF0, 32'h00000010, r, lat);
    n_cmp++;
    if (lat != LAT || r !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL flush_after_op: got %h after %0d cycles, expected ffffffff after %0d", r, lat, LAT);
    end
    if (lat < 0) recover(); else retire();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'h7FFFFFFF; in_b = 32'h7FFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b out_result=%h busy=%b, expected 1 0 0 0",
               in_ready, out_valid, out_result, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 32'hFFFFFFF9, 32'd3, r, lat);
    n_cmp++;
    if (lat != LAT || r !== 32'hFFFFFFEB) begin
      n_err++;
      $display("FAIL reset_after_op: got %h after %0d cycles, expected ffffffeb after %0d", r, lat, LAT);
    end
    if (lat < 0) recover(); else retire();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e, a, b;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      e = ref_mul(2'(i), a, b);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b, expected 1", i, in_ready);
      end
      run_op(2'(i), a, b, r, lat);
      n_cmp++;
      if (lat != LAT || r !== e) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: got %h after %0d cycles, expected %h after %0d", i, r, lat, e, LAT);
      end
      if (lat < 0) recover(); else retire();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Multi-cycle RV32M multiplier that uses the existing `adder_32bit` as its only arithmetic datapath.
- Sits in the execute stage beside the ALU and supports MUL, MULH, MULHSU and MULHU.
- Each cycle it drives the adder's A, B and carry_in inputs and consumes sum and carry_out: shift-add for the product, plus ~x+1 passes for sign handling.
- Valid/ready handshake on both sides; fixed latency.

Parameters:
- XLEN, 32: operand width. Only 32 is legal because the adder is fixed-width; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of any in-flight or held operation
- in_valid  in  1  operands valid
- in_ready  out  1  high only in IDLE
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_a  in  32  rs1
- in_b  in  32  rs2
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts
- out_result  out  32  MUL returns the low word; other ops return the high word
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0.
  - All internal registers cleared.
  - Reset mid-operation discards all work.
- Accept: in_valid & in_ready at a rising edge.
  - Latch op, a, b.
  - neg = (op==MULH|op==MUL) ? a[31]^b[31] : (op==MULHSU) ? a[31] : 0.
  - Go to ABS_A.
- ABS_A (1 cycle): if a is treated as signed (MUL, MULH, MULHSU) and a[31]=1, mcand = adder(~a, 0, cin=1); otherwise mcand = a.
- ABS_B (1 cycle):
  - b is treated as signed only for MUL and MULH; it is unsigned for MULHSU and MULHU.
  - lo = |b|, or b unchanged; hi = 0; cnt = 0.
- MUL (32 cycles):
  - Adder A = hi, B = lo[0] ? mcand : 0, cin = 0.
  - {hi, lo} <= {carry_out, sum, lo[31:1]}; cnt++.
  - Exit when cnt==31 is processed.
- NEG_LO (1 cycle):
  - If neg: lo = adder(~lo, 0, cin=1); store carry_out as c.
  - Else: hold values, c = 0.
- NEG_HI (1 cycle): if neg, hi = adder(~hi, 0, cin=c).
- DONE:
  - out_valid=1; out_result = (op==MUL) ? lo : hi.
  - Both outputs stay stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; in_ready=1 the next cycle (no same-cycle re-accept).
- Latency: out_valid asserts exactly 36 cycles after the accepting edge (1+1+32+1+1).
- The adder is combinational; all its outputs are captured in registers in the same cycle.
- The adder is never chained twice within one cycle.
- Boundaries:
  - |0x80000000| = 0x80000000, interpreted as unsigned 2^31.
  - Zero product with neg=1 yields 0: ~0+1 carries into hi, giving hi = ~0+1 = 0.
  - flush has priority over all other events, in every state. The state goes to IDLE and out_valid drops on the next edge, including while out_valid is held. in_valid in the same cycle as flush is ignored.
  - in_op, in_a and in_b changing after accept have no effect.

Decomposition:
- Package mul_pkg holds:
  - XLEN
  - op encodings: MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU
  - state enum: IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE
  - MUL_STEPS=32
  - MUL_LATENCY=36
- Sub-module: exactly one instance of the existing `adder_32bit`; its operand mux is local to mul_seq_32.
- No other sub-modules.

Test Plan:
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> out_result 0xFFFFFFFE at cycle 36; MUL of the same operands -> 0x00000001.
- MULH 0x80000000×0x80000000 -> 0x40000000; MUL of the same operands -> 0x00000000.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF (product 0xFFFFFFFF_00000001) -> 0xFFFFFFFF.
- MUL 7×0xFFFFFFFD -> 0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF; MULH 0×0xFFFFFFFF (neg=1, zero) -> 0x00000000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid=1 and out_result constant, in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- flush at MUL step 10 -> out_valid never asserts and in_ready=1 next cycle; rst_n low mid-MUL -> outputs take reset values immediately; a new op issued after either completes correctly in 36 cycles.
